// File: rtl/ysyx_22040175_hazard_sb_pkg.sv
// Shared constants for the hazard scoreboard / forwarding unit.
//   - default widths and depths used as parameter defaults
//   - forward-select encoding (0 = register file, k+1 = tracked stage k)
//   - scoreboard entry field widths
package ysyx_22040175_hazard_sb_pkg;

    localparam int unsigned XLEN_DEF             = 64;
    localparam int unsigned REG_ADDR_WIDTH_DEF   = 5;
    localparam int unsigned NUM_STAGES_DEF       = 3;
    localparam int unsigned LOAD_READY_STAGE_DEF = 1;
    localparam int unsigned CNT_W_DEF            = 32;

    // Forward-select encoding
    localparam int unsigned FWD_RF         = 0;
    localparam int unsigned FWD_STAGE_BASE = 1;

    // Scoreboard entry fields: {valid, waddr, is_load}
    localparam int unsigned ENT_VALID_W = 1;
    localparam int unsigned ENT_LOAD_W  = 1;

endpackage

// File: rtl/ysyx_22040175_hazard_sb_if.sv
// Bus between the ID stage and the hazard scoreboard.
//   master: ID-side driver of the decoded instruction, regfile data,
//           per-stage results, flush and hold
//   slave : scoreboard returning stall, forward selects, resolved operands
//           and the performance counters
interface ysyx_22040175_hazard_sb_if #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned SEL_W          = $clog2(NUM_STAGES + 1),
    parameter int unsigned CNT_W          = 32
) ();

    logic                          id_valid;
    logic [REG_ADDR_WIDTH-1:0]     id_rs1;
    logic [REG_ADDR_WIDTH-1:0]     id_rs2;
    logic                          id_rs1_used;
    logic                          id_rs2_used;
    logic                          id_wen;
    logic [REG_ADDR_WIDTH-1:0]     id_waddr;
    logic                          id_is_load;
    logic [XLEN-1:0]               rf_rdata1;
    logic [XLEN-1:0]               rf_rdata2;
    logic [NUM_STAGES*XLEN-1:0]    stage_wdata;
    logic                          flush;
    logic                          hold;

    logic                          stall;
    logic [SEL_W-1:0]              fwd_sel1;
    logic [SEL_W-1:0]              fwd_sel2;
    logic [XLEN-1:0]               op1_data;
    logic [XLEN-1:0]               op2_data;
    logic [CNT_W-1:0]              stall_cnt;
    logic [CNT_W-1:0]              fwd_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_wen, id_waddr, id_is_load, rf_rdata1, rf_rdata2,
               stage_wdata, flush, hold,
        input  stall, fwd_sel1, fwd_sel2, op1_data, op2_data,
               stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_wen, id_waddr, id_is_load, rf_rdata1, rf_rdata2,
               stage_wdata, flush, hold,
        output stall, fwd_sel1, fwd_sel2, op1_data, op2_data,
               stall_cnt, fwd_cnt
    );

endinterface

// File: rtl/ysyx_22040175_fwd_lookup.sv
// Priority match of one source operand against the in-flight writes.
//   i_valid/i_waddr/i_is_load : scoreboard entries, index 0 = youngest (EX)
//   i_rs/i_used               : source index and whether it is read
//   i_rf_rdata/i_stage_wdata  : fallback and per-stage result data
//   o_fwd_sel_c/o_data_c      : selected source and operand value
//   o_load_use_c              : youngest producer is a load not yet ready
module ysyx_22040175_fwd_lookup
    import ysyx_22040175_hazard_sb_pkg::*;
#(
    parameter int unsigned XLEN             = XLEN_DEF,
    parameter int unsigned REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_STAGES       = NUM_STAGES_DEF,
    parameter int unsigned LOAD_READY_STAGE = LOAD_READY_STAGE_DEF,
    parameter int unsigned SEL_W            = $clog2(NUM_STAGES + 1)
) (
    input  logic [NUM_STAGES-1:0]                i_valid,
    input  logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] i_waddr,
    input  logic [NUM_STAGES-1:0]                i_is_load,
    input  logic [REG_ADDR_WIDTH-1:0]            i_rs,
    input  logic                                 i_used,
    input  logic [XLEN-1:0]                      i_rf_rdata,
    input  logic [NUM_STAGES*XLEN-1:0]           i_stage_wdata,
    output logic [SEL_W-1:0]                     o_fwd_sel_c,
    output logic [XLEN-1:0]                      o_data_c,
    output logic                                 o_load_use_c
);

    logic w_hit;

    // Scan from youngest to oldest; the first match decides.
    always_comb begin
        o_fwd_sel_c  = SEL_W'(FWD_RF);
        o_data_c     = i_rf_rdata;
        o_load_use_c = 1'b0;
        w_hit        = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (!w_hit && i_valid[k] && i_used && (i_rs != '0) &&
                (i_waddr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == i_rs)) begin
                w_hit = 1'b1;
                if (i_is_load[k] && (k < LOAD_READY_STAGE)) begin
                    o_load_use_c = 1'b1;
                end else begin
                    o_fwd_sel_c = SEL_W'(k + FWD_STAGE_BASE);
                    o_data_c    = i_stage_wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22040175_hazard_sb.sv
// Hazard scoreboard and forwarding unit between ID and EX/MEM/WB.
//   clk, rst : clock, synchronous active-high reset
//   sb       : slave side of the ID/scoreboard bus (decoded instruction,
//              regfile and stage data, flush/hold in; stall, forward
//              selects, resolved operands and perf counters out)
// Tracks in-flight register writes in a shift register, stalls on
// load-use, and forwards from the youngest producing stage.
module ysyx_22040175_hazard_sb
    import ysyx_22040175_hazard_sb_pkg::*;
#(
    parameter int unsigned XLEN             = XLEN_DEF,
    parameter int unsigned REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
    parameter int unsigned NUM_STAGES       = NUM_STAGES_DEF,
    parameter int unsigned LOAD_READY_STAGE = LOAD_READY_STAGE_DEF,
    parameter int unsigned SEL_W            = $clog2(NUM_STAGES + 1),
    parameter int unsigned CNT_W            = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22040175_hazard_sb_if.slave  sb
);

    localparam int unsigned CNT_EXT_W = CNT_W + 1;
    localparam int unsigned RAW       = REG_ADDR_WIDTH;

    // Scoreboard entries, index 0 = EX
    logic [NUM_STAGES-1:0]     r_valid;
    logic [NUM_STAGES*RAW-1:0] r_waddr;
    logic [NUM_STAGES-1:0]     r_is_load;
    logic [CNT_W-1:0]          r_stall_cnt;
    logic [CNT_W-1:0]          r_fwd_cnt;

    logic [SEL_W-1:0]     w_sel1;
    logic [SEL_W-1:0]     w_sel2;
    logic [XLEN-1:0]      w_op1;
    logic [XLEN-1:0]      w_op2;
    logic                 w_lu1;
    logic                 w_lu2;
    logic                 w_stall;
    logic                 w_issue;
    logic                 w_ins_valid;
    logic [1:0]           w_fwd_inc;
    logic [CNT_EXT_W-1:0] w_stall_sum;
    logic [CNT_EXT_W-1:0] w_fwd_sum;
    logic [CNT_W-1:0]     w_stall_cnt_nxt;
    logic [CNT_W-1:0]     w_fwd_cnt_nxt;

    ysyx_22040175_fwd_lookup #(
        .XLEN(XLEN), .REG_ADDR_WIDTH(RAW), .NUM_STAGES(NUM_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE), .SEL_W(SEL_W)
    ) u_lookup1 (
        .i_valid(r_valid), .i_waddr(r_waddr), .i_is_load(r_is_load),
        .i_rs(sb.id_rs1), .i_used(sb.id_rs1_used),
        .i_rf_rdata(sb.rf_rdata1), .i_stage_wdata(sb.stage_wdata),
        .o_fwd_sel_c(w_sel1), .o_data_c(w_op1), .o_load_use_c(w_lu1)
    );

    ysyx_22040175_fwd_lookup #(
        .XLEN(XLEN), .REG_ADDR_WIDTH(RAW), .NUM_STAGES(NUM_STAGES),
        .LOAD_READY_STAGE(LOAD_READY_STAGE), .SEL_W(SEL_W)
    ) u_lookup2 (
        .i_valid(r_valid), .i_waddr(r_waddr), .i_is_load(r_is_load),
        .i_rs(sb.id_rs2), .i_used(sb.id_rs2_used),
        .i_rf_rdata(sb.rf_rdata2), .i_stage_wdata(sb.stage_wdata),
        .o_fwd_sel_c(w_sel2), .o_data_c(w_op2), .o_load_use_c(w_lu2)
    );

    // Flush kills the ID instruction, so it can never cause a load-use stall.
    always_comb begin
        w_stall     = sb.hold | (sb.id_valid & (w_lu1 | w_lu2) & ~sb.flush);
        w_issue     = sb.id_valid & ~w_stall & ~sb.flush;
        w_ins_valid = w_issue & sb.id_wen & (sb.id_waddr != '0);
        w_fwd_inc   = 2'(w_sel1 != '0) + 2'(w_sel2 != '0);
    end

    // Saturating counter next values: overflow into the extra bit clamps.
    always_comb begin
        w_stall_sum     = CNT_EXT_W'(r_stall_cnt) + CNT_EXT_W'(1);
        w_fwd_sum       = CNT_EXT_W'(r_fwd_cnt) + CNT_EXT_W'(w_fwd_inc);
        w_stall_cnt_nxt = w_stall_sum[CNT_W] ? '1 : w_stall_sum[CNT_W-1:0];
        w_fwd_cnt_nxt   = w_fwd_sum[CNT_W] ? '1 : w_fwd_sum[CNT_W-1:0];
    end

    // Entry shift; a stall or flush shifts in a bubble, hold freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= '0;
            r_waddr   <= '0;
            r_is_load <= '0;
        end else if (!sb.hold) begin
            for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                r_valid[k]               <= r_valid[k-1];
                r_waddr[k*RAW +: RAW]    <= r_waddr[(k-1)*RAW +: RAW];
                r_is_load[k]             <= r_is_load[k-1];
            end
            r_valid[0]      <= w_ins_valid;
            r_waddr[RAW-1:0] <= sb.id_waddr;
            r_is_load[0]    <= sb.id_is_load;
        end
    end

    // Performance counters; hold implies stall, so w_issue is already 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && !sb.hold) begin
                r_stall_cnt <= w_stall_cnt_nxt;
            end
            if (w_issue) begin
                r_fwd_cnt <= w_fwd_cnt_nxt;
            end
        end
    end

    assign sb.stall     = w_stall;
    assign sb.fwd_sel1  = w_sel1;
    assign sb.fwd_sel2  = w_sel2;
    assign sb.op1_data  = w_op1;
    assign sb.op2_data  = w_op2;
    assign sb.stall_cnt = r_stall_cnt;
    assign sb.fwd_cnt   = r_fwd_cnt;

endmodule
